store_queue: RTL and testbench

STORE_QUEUE -- requirements
Module: store_queue

---
 rtl/store_queue_pkg.sv | 43 ++++
 rtl/sq_bypass_merge.sv | 57 +++++
 rtl/store_queue.sv | 162 ++++++++++++++++
 tb/tb_store_queue.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_queue_pkg.sv
// Shared definitions for the store queue.
// Holds the default data/address width, ROB tag width, funct3 size
// encodings, the width of the stored size field, the per-entry record and a
// helper that turns (size, byte offset) into a 4-lane byte mask.
package store_queue_pkg;

  localparam int WORD_SIZE        = 32;
  localparam int ROB_ENTRY_WIDTH  = 5;
  localparam int SIZE_WRITE_WIDTH = 3;

  // funct3[1:0] access-size encodings; funct3[2] marks unsigned loads.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // One queue slot. data/mask are the store already placed on its byte
  // lanes within the 32-bit word, so the bypass path needs no shifting.
  typedef struct packed {
    logic                        valid;
    logic                        committed;
    logic [WORD_SIZE-3:0]        word_addr;
    logic [1:0]                  offset;
    logic [SIZE_WRITE_WIDTH-1:0] size;
    logic [WORD_SIZE-1:0]        value;
    logic [31:0]                 data;
    logic [3:0]                  mask;
    logic [ROB_ENTRY_WIDTH-1:0]  rob_id;
  } sq_entry_t;

  // Byte lanes touched by an access; lanes past 3 fall off the word.
  function automatic logic [3:0] lane_mask(input logic [1:0] sz,
                                           input logic [1:0] off);
    logic [6:0] m;
    case (sz)
      SZ_BYTE: m = 7'b0000001;
      SZ_HALF: m = 7'b0000011;
      default: m = 7'b0001111;
    endcase
    m = m << off;
    return m[3:0];
  endfunction

endpackage

// File: rtl/sq_bypass_merge.sv
// Store-to-load bypass merge.
// Entries arrive ordered oldest (index 0) to youngest; per byte lane the
// youngest hitting entry wins. The merged word is shifted down to the load's
// byte offset and sign/zero extended per load_size.
//   load_valid/load_offset/load_size : the load being looked up
//   hit  : entry is valid and matches the load's word address
//   mask/data : entry byte mask and lane-aligned data
//   bypass_needed/possible/value : lookup results (all zero when idle)
module sq_bypass_merge
  import store_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       load_valid,
  input  logic [1:0]                 load_offset,
  input  logic [2:0]                 load_size,
  input  logic [DEPTH-1:0]           hit,
  input  logic [DEPTH-1:0][3:0]      mask,
  input  logic [DEPTH-1:0][31:0]     data,
  output logic                       bypass_needed,
  output logic                       bypass_possible,
  output logic [WORD_SIZE-1:0]       bypass_value
);

  logic [31:0] merged;
  logic [31:0] shifted;
  logic [31:0] ext;
  logic [3:0]  supplied;
  logic [3:0]  req;

  always_comb begin
    merged   = '0;
    supplied = '0;
    // Later (younger) entries overwrite earlier ones lane by lane.
    for (int k = 0; k < DEPTH; k++) begin
      for (int b = 0; b < 4; b++) begin
        if (hit[k] && mask[k][b]) begin
          merged[8*b +: 8] = data[k][8*b +: 8];
          supplied[b]      = 1'b1;
        end
      end
    end
    req     = lane_mask(load_size[1:0], load_offset);
    shifted = merged >> {load_offset, 3'b000};
    case (load_size[1:0])
      SZ_BYTE: ext = load_size[2] ? {24'h0, shifted[7:0]}
                                  : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: ext = load_size[2] ? {16'h0, shifted[15:0]}
                                  : {{16{shifted[15]}}, shifted[15:0]};
      default: ext = shifted;
    endcase
    bypass_needed   = load_valid && (|(req & supplied));
    bypass_possible = load_valid && ((req & ~supplied) == 4'b0000);
    bypass_value    = load_valid ? ext : '0;
  end

endmodule

// File: rtl/store_queue.sv
// In-order store queue between the ROB and the data cache.
// Stores are allocated at the tail, committed by the ROB by tag, and drained
// to the cache from the head. Younger loads can pick up queued data through
// the bypass lookup. The widths of the shared entry record come from
// store_queue_pkg, so WORD_SIZE/ROB_ENTRY_WIDTH must match the package.
//
// Handshakes: allocation is store (valid) against !full (ready); a store
// seen while full is dropped, so upstream must hold it. Draining is
// cache_wenable (valid) against store_success (ready); the head pops on an
// edge where both are high, and store_success alone does nothing.
//
// Ports: clk, rst (sync, active-high); store/store_value/physical_address/
// op_size/input_rob_id allocate; store_permission(+_rob_id) commits; flush
// drops uncommitted entries; load_valid/load_addr/load_size drive bypass;
// cache_* and store_success drain; full/empty status; bypass_* results;
// dbg_head/dbg_tail/dbg_count expose pointer state.
module store_queue
  import store_queue_pkg::*;
#(
  parameter int WORD_SIZE       = store_queue_pkg::WORD_SIZE,
  parameter int DEPTH           = 4,
  parameter int ROB_ENTRY_WIDTH = store_queue_pkg::ROB_ENTRY_WIDTH,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       store,
  input  logic [WORD_SIZE-1:0]       store_value,
  input  logic [WORD_SIZE-1:0]       physical_address,
  input  logic [2:0]                 op_size,
  input  logic [ROB_ENTRY_WIDTH-1:0] input_rob_id,
  input  logic                       store_permission,
  input  logic [ROB_ENTRY_WIDTH-1:0] store_permission_rob_id,
  input  logic                       flush,
  input  logic                       load_valid,
  input  logic [WORD_SIZE-1:0]       load_addr,
  input  logic [2:0]                 load_size,
  input  logic                       store_success,
  output logic                       cache_wenable,
  output logic [WORD_SIZE-1:0]       cache_store_value,
  output logic [WORD_SIZE-1:0]       cache_physical_address,
  output logic [2:0]                 cache_store_size,
  output logic                       full,
  output logic                       empty,
  output logic                       bypass_needed,
  output logic                       bypass_possible,
  output logic [WORD_SIZE-1:0]       bypass_value,
  output logic [PW-1:0]              dbg_head,
  output logic [PW-1:0]              dbg_tail,
  output logic [CW-1:0]              dbg_count
);

  sq_entry_t           entries [DEPTH];
  sq_entry_t           new_entry;
  sq_entry_t           head_entry;
  logic [PW-1:0]       head, tail, idx;
  logic [CW-1:0]       count, committed_count;
  logic                push, pop;
  logic [DEPTH-1:0]    perm_hit, eff_committed;
  logic [DEPTH-1:0]        age_hit;
  logic [DEPTH-1:0][3:0]   age_mask;
  logic [DEPTH-1:0][31:0]  age_data;

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign head_entry = entries[head];

  assign cache_wenable          = head_entry.valid && head_entry.committed;
  assign cache_store_value      = head_entry.value;
  assign cache_physical_address = {head_entry.word_addr, head_entry.offset};
  assign cache_store_size       = head_entry.size;

  assign pop  = store_success && cache_wenable;
  assign push = store && !full && !flush;

  assign dbg_head  = head;
  assign dbg_tail  = tail;
  assign dbg_count = count;

  // A commit arriving with a flush must survive it, so the flush decision
  // uses the post-permission committed view. Commits are in order, which
  // keeps the surviving entries contiguous from the head.
  always_comb begin
    committed_count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      perm_hit[i] = store_permission && entries[i].valid &&
                    (entries[i].rob_id == store_permission_rob_id);
      eff_committed[i] = entries[i].valid &&
                         (entries[i].committed || perm_hit[i]);
      committed_count  = committed_count + CW'(eff_committed[i]);
    end
  end

  always_comb begin
    new_entry           = '0;
    new_entry.valid     = 1'b1;
    new_entry.committed = 1'b0;
    new_entry.word_addr = physical_address[WORD_SIZE-1:2];
    new_entry.offset    = physical_address[1:0];
    new_entry.size      = op_size;
    new_entry.value     = store_value;
    new_entry.data      = store_value << {physical_address[1:0], 3'b000};
    new_entry.mask      = lane_mask(op_size[1:0], physical_address[1:0]);
    new_entry.rob_id    = input_rob_id;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].valid     <= 1'b0;
        entries[i].committed <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (perm_hit[i]) entries[i].committed <= 1'b1;
        if (flush && !eff_committed[i]) entries[i].valid <= 1'b0;
        if (pop && (head == PW'(i))) begin
          entries[i].valid     <= 1'b0;
          entries[i].committed <= 1'b0;
        end
      end
      if (push) entries[tail] <= new_entry;
      if (pop) head <= head + PW'(1);
      if (flush) begin
        tail  <= head + committed_count[PW-1:0];
        count <= committed_count - CW'(pop);
      end else begin
        if (push) tail <= tail + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Present entries to the merge ordered oldest to youngest.
  always_comb begin
    idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx         = head + PW'(k);
      age_hit[k]  = entries[idx].valid &&
                    (entries[idx].word_addr == load_addr[WORD_SIZE-1:2]);
      age_mask[k] = entries[idx].mask;
      age_data[k] = entries[idx].data;
    end
  end

  sq_bypass_merge #(.DEPTH(DEPTH)) u_merge (
    .load_valid      (load_valid),
    .load_offset     (load_addr[1:0]),
    .load_size       (load_size),
    .hit             (age_hit),
    .mask            (age_mask),
    .data            (age_data),
    .bypass_needed   (bypass_needed),
    .bypass_possible (bypass_possible),
    .bypass_value    (bypass_value)
  );

endmodule

// File: tb/tb_store_queue.sv
module tb_store_queue;
  import store_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int RW    = ROB_ENTRY_WIDTH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          store;
  logic [31:0]   store_value;
  logic [31:0]   physical_address;
  logic [2:0]    op_size;
  logic [RW-1:0] input_rob_id;
  logic          store_permission;
  logic [RW-1:0] store_permission_rob_id;
  logic          flush;
  logic          load_valid;
  logic [31:0]   load_addr;
  logic [2:0]    load_size;
  logic          store_success;
  logic          cache_wenable;
  logic [31:0]   cache_store_value;
  logic [31:0]   cache_physical_address;
  logic [2:0]    cache_store_size;
  logic          full, empty;
  logic          bypass_needed, bypass_possible;
  logic [31:0]   bypass_value;
  logic [1:0]    dbg_head, dbg_tail;
  logic [2:0]    dbg_count;

  int n_compared   = 0;
  int n_mismatched = 0;

  store_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .store(store), .store_value(store_value),
    .physical_address(physical_address), .op_size(op_size),
    .input_rob_id(input_rob_id), .store_permission(store_permission),
    .store_permission_rob_id(store_permission_rob_id), .flush(flush),
    .load_valid(load_valid), .load_addr(load_addr), .load_size(load_size),
    .store_success(store_success), .cache_wenable(cache_wenable),
    .cache_store_value(cache_store_value),
    .cache_physical_address(cache_physical_address),
    .cache_store_size(cache_store_size), .full(full), .empty(empty),
    .bypass_needed(bypass_needed), .bypass_possible(bypass_possible),
    .bypass_value(bypass_value), .dbg_head(dbg_head), .dbg_tail(dbg_tail),
    .dbg_count(dbg_count)
  );

  // ---------------- reference model ----------------
  // The queue is a list of pending stores, oldest first; bypass is resolved
  // byte address by byte address.
  typedef struct {
    logic [31:0]   addr;
    logic [2:0]    size;
    logic [31:0]   value;
    logic [RW-1:0] rob;
    bit            committed;
  } m_entry_t;

  m_entry_t mq[$];

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  task automatic model_update();
    int  sz;
    bit  do_push, do_pop;
    m_entry_t keep[$];
    m_entry_t ne;
    sz = mq.size();
    if (rst) begin
      mq.delete();
      return;
    end
    do_push = store && (sz < DEPTH) && !flush;
    do_pop  = store_success && (sz > 0) && mq[0].committed;
    if (store_permission)
      foreach (mq[i]) if (mq[i].rob == store_permission_rob_id) mq[i].committed = 1'b1;
    if (flush) begin
      foreach (mq[i]) if (mq[i].committed) keep.push_back(mq[i]);
      mq = keep;
    end
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      ne.addr = physical_address; ne.size = op_size; ne.value = store_value;
      ne.rob = input_rob_id; ne.committed = 1'b0;
      mq.push_back(ne);
    end
  endtask

  function automatic void model_bypass(input logic [31:0] la, input logic [2:0] ls,
                                       output logic need, output logic poss,
                                       output logic [31:0] val);
    int n;
    logic [31:0] raw;
    logic hit_b;
    logic [7:0] b;
    need = 1'b0; poss = 1'b1; raw = '0;
    n = nbytes(ls[1:0]);
    for (int j = 0; j < n; j++) begin
      if (int'(la[1:0]) + j > 3) break;
      hit_b = 1'b0; b = '0;
      for (int e = 0; e < mq.size(); e++) begin
        for (int k = 0; k < nbytes(mq[e].size[1:0]); k++) begin
          if ((int'(mq[e].addr[1:0]) + k <= 3) && (mq[e].addr + 32'(k) == la + 32'(j))) begin
            hit_b = 1'b1;
            b = mq[e].value[8*k +: 8];
          end
        end
      end
      if (hit_b) begin need = 1'b1; raw[8*j +: 8] = b; end
      else poss = 1'b0;
    end
    case (n)
      1:       val = ls[2] ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2:       val = ls[2] ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: val = raw;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    rst = 1'b0; store = 1'b0; store_value = '0; physical_address = '0;
    op_size = '0; input_rob_id = '0; store_permission = 1'b0;
    store_permission_rob_id = '0; flush = 1'b0; load_valid = 1'b0;
    load_addr = '0; load_size = '0; store_success = 1'b0;
  endtask

  // Inputs change 1 time unit after a rising edge and stay put across the next.
  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic push_store(input logic [31:0] a, input logic [2:0] s,
                            input logic [31:0] v, input logic [RW-1:0] r);
    store = 1'b1; physical_address = a; op_size = s; store_value = v; input_rob_id = r;
    tick();
    store = 1'b0;
  endtask

  task automatic permit(input logic [RW-1:0] r);
    store_permission = 1'b1; store_permission_rob_id = r;
    tick();
    store_permission = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] s);
    load_valid = 1'b1; load_addr = a; load_size = s;
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1; store = 1'b1; physical_address = 32'h40; store_value = 32'h1;
    store_success = 1'b1; flush = 1'b1;
    tick(); tick();
    idle_inputs();
    load(32'h40, 3'd2);
    n_compared++; if (full !== 1'b0) begin n_mismatched++; $display("FAIL reset_full: got %b want 0", full); end
    n_compared++; if (empty !== 1'b1) begin n_mismatched++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_compared++; if (cache_wenable !== 1'b0) begin n_mismatched++; $display("FAIL reset_wen: got %b want 0", cache_wenable); end
    n_compared++; if (dbg_count !== 3'd0) begin n_mismatched++; $display("FAIL reset_count: got %0d want 0", dbg_count); end
    n_compared++; if (bypass_needed !== 1'b0 || bypass_possible !== 1'b0 || bypass_value !== 32'h0) begin
      n_mismatched++; $display("FAIL reset_bypass: got %b/%b/%h want 0/0/0", bypass_needed, bypass_possible, bypass_value); end
    load_valid = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      push_store(32'h400 + 32'(4*i), 3'd2, $urandom, RW'(i));
      if (i == 2) begin
        n_compared++; if (full !== 1'b0) begin n_mismatched++; $display("FAIL fill_full3: got %b want 0", full); end
      end
    end
    n_compared++; if (full !== 1'b1) begin n_mismatched++; $display("FAIL fill_full4: got %b want 1", full); end
    push_store(32'h410, 3'd2, 32'hDEADBEEF, RW'(9));
    n_compared++; if (dbg_count !== 3'd4) begin n_mismatched++; $display("FAIL fill_ignored: got %0d want 4", dbg_count); end
    load(32'h410, 3'd2);
    n_compared++; if (bypass_needed !== 1'b0) begin n_mismatched++; $display("FAIL fill_dropped_data: got %b want 0", bypass_needed); end
    load_valid = 1'b0;
    do_reset();
  endtask

  task automatic test_commit_drain();
    push_store(32'h1003, 3'd0, 32'hAB, RW'(7));
    n_compared++; if (cache_wenable !== 1'b0) begin n_mismatched++; $display("FAIL drain_uncommitted: got %b want 0", cache_wenable); end
    store_success = 1'b1; tick(); store_success = 1'b0;
    n_compared++; if (dbg_count !== 3'd1) begin n_mismatched++; $display("FAIL drain_spurious_success: got %0d want 1", dbg_count); end
    permit(RW'(3));
    n_compared++; if (cache_wenable !== 1'b0) begin n_mismatched++; $display("FAIL drain_wrong_rob: got %b want 0", cache_wenable); end
    permit(RW'(7));
    n_compared++; if (cache_wenable !== 1'b1) begin n_mismatched++; $display("FAIL drain_wen: got %b want 1", cache_wenable); end
    n_compared++; if (cache_physical_address !== 32'h1003) begin n_mismatched++; $display("FAIL drain_addr: got %h want 00001003", cache_physical_address); end
    n_compared++; if (cache_store_value !== 32'hAB || cache_store_size !== 3'd0) begin
      n_mismatched++; $display("FAIL drain_value: got %h/%0d want 000000ab/0", cache_store_value, cache_store_size); end
    store_success = 1'b1; tick(); store_success = 1'b0;
    n_compared++; if (empty !== 1'b1) begin n_mismatched++; $display("FAIL drain_empty: got %b want 1", empty); end
    do_reset();
  endtask

  task automatic test_bypass_merge();
    push_store(32'h2000, 3'd2, 32'h11223344, RW'(1));
    push_store(32'h2001, 3'd0, 32'hFF, RW'(2));
    load(32'h2000, 3'd2);
    n_compared++; if (bypass_possible !== 1'b1) begin n_mismatched++; $display("FAIL merge_possible: got %b want 1", bypass_possible); end
    n_compared++; if (bypass_value !== 32'h1122FF44) begin n_mismatched++; $display("FAIL merge_value: got %h want 1122ff44", bypass_value); end
    load(32'h2001, 3'd4);
    n_compared++; if (bypass_value !== 32'hFF) begin n_mismatched++; $display("FAIL merge_lbu: got %h want 000000ff", bypass_value); end
    load(32'h2002, 3'd1);
    n_compared++; if (bypass_value !== 32'h1122) begin n_mismatched++; $display("FAIL merge_lh_hi: got %h want 00001122", bypass_value); end
    load(32'h2004, 3'd2);
    n_compared++; if (bypass_needed !== 1'b0) begin n_mismatched++; $display("FAIL merge_other_word: got %b want 0", bypass_needed); end
    load_valid = 1'b0;
    do_reset();
  endtask

  task automatic test_bypass_partial();
    push_store(32'h3000, 3'd1, 32'h8001, RW'(4));
    load(32'h3001, 3'd0);
    n_compared++; if (bypass_value !== 32'hFFFFFF80) begin n_mismatched++; $display("FAIL partial_lb: got %h want ffffff80", bypass_value); end
    load(32'h3000, 3'd2);
    n_compared++; if (bypass_needed !== 1'b1 || bypass_possible !== 1'b0) begin
      n_mismatched++; $display("FAIL partial_lw: got %b/%b want 1/0", bypass_needed, bypass_possible); end
    load(32'h3000, 3'd5);
    n_compared++; if (bypass_value !== 32'h8001) begin n_mismatched++; $display("FAIL partial_lhu: got %h want 00008001", bypass_value); end
    load_valid = 1'b0; #1;
    n_compared++; if (bypass_needed !== 1'b0 || bypass_possible !== 1'b0 || bypass_value !== 32'h0) begin
      n_mismatched++; $display("FAIL partial_idle: got %b/%b/%h want 0/0/0", bypass_needed, bypass_possible, bypass_value); end
    do_reset();
  endtask

  task automatic test_flush();
    push_store(32'h500, 3'd2, 32'hA0A0A0A0, RW'(1));
    push_store(32'h504, 3'd2, 32'hB1B1B1B1, RW'(2));
    push_store(32'h508, 3'd2, 32'hC2C2C2C2, RW'(3));
    permit(RW'(1));
    flush = 1'b1; store = 1'b1; physical_address = 32'h50C; op_size = 3'd2;
    store_value = 32'hD3D3D3D3; input_rob_id = RW'(4);
    tick();
    flush = 1'b0; store = 1'b0;
    n_compared++; if (dbg_count !== 3'd1) begin n_mismatched++; $display("FAIL flush_count: got %0d want 1", dbg_count); end
    n_compared++; if (dbg_head !== 2'd0 || dbg_tail !== 2'd1) begin
      n_mismatched++; $display("FAIL flush_ptrs: got head %0d tail %0d want 0/1", dbg_head, dbg_tail); end
    load(32'h50C, 3'd2);
    n_compared++; if (bypass_needed !== 1'b0) begin n_mismatched++; $display("FAIL flush_store_dropped: got %b want 0", bypass_needed); end
    load(32'h504, 3'd2);
    n_compared++; if (bypass_needed !== 1'b0) begin n_mismatched++; $display("FAIL flush_invalidated: got %b want 0", bypass_needed); end
    load_valid = 1'b0;
    n_compared++; if (cache_wenable !== 1'b1 || cache_physical_address !== 32'h500) begin
      n_mismatched++; $display("FAIL flush_drain: got %b/%h want 1/00000500", cache_wenable, cache_physical_address); end
    store_success = 1'b1; tick(); store_success = 1'b0;
    n_compared++; if (empty !== 1'b1) begin n_mismatched++; $display("FAIL flush_drained: got %b want 1", empty); end
    do_reset();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      push_store(32'h600 + 32'(4*i), 3'd2, $urandom, RW'(i + 1));
      if (i == 2) begin
        n_compared++; if (dbg_tail !== 2'd3) begin n_mismatched++; $display("FAIL b2b_tail3: got %0d want 3", dbg_tail); end
      end
    end
    n_compared++; if (dbg_tail !== 2'd0) begin n_mismatched++; $display("FAIL b2b_tail_wrap: got %0d want 0", dbg_tail); end
    permit(RW'(1));
    store_success = 1'b1; store = 1'b1; physical_address = 32'h610; op_size = 3'd2;
    store_value = 32'h12345678; input_rob_id = RW'(5);
    tick();
    store_success = 1'b0; store = 1'b0;
    n_compared++; if (dbg_count !== 3'd3 || dbg_head !== 2'd1 || dbg_tail !== 2'd0) begin
      n_mismatched++; $display("FAIL b2b_refused: got count %0d head %0d tail %0d want 3/1/0", dbg_count, dbg_head, dbg_tail); end
    push_store(32'h610, 3'd2, 32'h12345678, RW'(5));
    n_compared++; if (dbg_count !== 3'd4 || dbg_tail !== 2'd1) begin
      n_mismatched++; $display("FAIL b2b_next_push: got count %0d tail %0d want 4/1", dbg_count, dbg_tail); end
    do_reset();
  endtask

  task automatic test_reset_mid_drain();
    push_store(32'h700, 3'd2, 32'h77777777, RW'(6));
    permit(RW'(6));
    rst = 1'b1; store_success = 1'b0;
    tick();
    rst = 1'b0;
    n_compared++; if (cache_wenable !== 1'b0 || empty !== 1'b1) begin
      n_mismatched++; $display("FAIL reset_mid_drain: got wen %b empty %b want 0/1", cache_wenable, empty); end
  endtask

  task automatic test_random();
    logic [RW-1:0] rob_ctr;
    logic e_need, e_poss;
    logic [31:0] e_val;
    bit used;
    bit e_wen;
    int first_unc;
    logic [2:0] lsz_pool [5];
    lsz_pool[0] = 3'd0; lsz_pool[1] = 3'd1; lsz_pool[2] = 3'd2;
    lsz_pool[3] = 3'd4; lsz_pool[4] = 3'd5;
    rob_ctr = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      idle_inputs();
      // Fresh tag not held by any live entry.
      do begin
        rob_ctr = rob_ctr + RW'(1);
        used = 1'b0;
        foreach (mq[i]) if (mq[i].rob == rob_ctr) used = 1'b1;
      end while (used);
      store            = ($urandom_range(0, 2) != 0);
      physical_address = 32'h100 + 32'($urandom_range(0, 15));
      op_size          = 3'($urandom_range(0, 2));
      store_value      = $urandom;
      input_rob_id     = rob_ctr;
      first_unc = -1;
      foreach (mq[i]) if (first_unc < 0 && !mq[i].committed) first_unc = i;
      if ($urandom_range(0, 9) < 4 && first_unc >= 0) begin
        store_permission = 1'b1;
        store_permission_rob_id = mq[first_unc].rob;
      end else if ($urandom_range(0, 9) == 0) begin
        store_permission = 1'b1;
        store_permission_rob_id = rob_ctr;
      end
      store_success = ($urandom_range(0, 1) == 1);
      flush         = ($urandom_range(0, 19) == 0);
      rst           = ($urandom_range(0, 99) == 0);
      load_valid    = ($urandom_range(0, 9) < 7);
      load_addr     = 32'h100 + 32'($urandom_range(0, 15));
      load_size     = lsz_pool[$urandom_range(0, 4)];
      #1;
      e_wen = (mq.size() > 0) && mq[0].committed;
      if (load_valid) model_bypass(load_addr, load_size, e_need, e_poss, e_val);
      else begin e_need = 1'b0; e_poss = 1'b0; e_val = '0; end
      n_compared++; if (dbg_count !== 3'(mq.size()) || full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0)) begin
        n_mismatched++; $display("FAIL rnd_occupancy c%0d: got count %0d full %b empty %b want %0d", cyc, dbg_count, full, empty, mq.size()); end
      n_compared++; if (cache_wenable !== e_wen) begin
        n_mismatched++; $display("FAIL rnd_wen c%0d: got %b want %b", cyc, cache_wenable, e_wen); end
      if (e_wen) begin
        n_compared++; if (cache_physical_address !== mq[0].addr || cache_store_value !== mq[0].value || cache_store_size !== mq[0].size) begin
          n_mismatched++; $display("FAIL rnd_drain c%0d: got %h/%h/%0d want %h/%h/%0d", cyc, cache_physical_address, cache_store_value, cache_store_size, mq[0].addr, mq[0].value, mq[0].size); end
      end
      n_compared++; if (bypass_needed !== e_need || bypass_possible !== e_poss || bypass_value !== e_val) begin
        n_mismatched++; $display("FAIL rnd_bypass c%0d: got %b/%b/%h want %b/%b/%h", cyc, bypass_needed, bypass_possible, bypass_value, e_need, e_poss, e_val); end
      tick();
    end
    idle_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_inputs();
    @(posedge clk); #1;
    test_reset();
    test_fill();
    test_commit_drain();
    test_bypass_merge();
    test_bypass_partial();
    test_flush();
    test_back_to_back();
    test_reset_mid_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
